mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its outputs.
- Issues load/store transactions on a valid/ready data-memory port and formats load data (byte/half/word, sign/zero extension).
- Selects the writeback value and registers it for the register file.
- Drives stall_o to freeze upstream stages while a memory transaction is outstanding.

---
 rtl/mem_wb_stage_pkg.sv | 57 +++++
 rtl/mem_wb_stage_load_align.sv | 42 ++++
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage_pkg                                                     |
// | Shared access-size and FSM state types plus store-lane helpers for   |
// | the memory-access / writeback stage.                                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    BYTE = 3'b000,
    HALF = 3'b001,
    WORD = 3'b010
  } mem_size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;

  // Undefined size encodings count as misaligned so they never reach the bus.
  function automatic logic access_misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = lo[0];
      WORD:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strobe(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      BYTE:    strb = 4'b0001 << lo;
      HALF:    strb = lo[1] ? 4'b1100 : 4'b0011;
      WORD:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Store data replicated across all lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      BYTE:    lanes = {4{data[7:0]}};
      HALF:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage_load_align                                              |
// | Extracts a byte/half/word from the returned memory word and sign- or |
// | zero-extends it to 32 bits.                                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_wb_stage_load_align (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  input  logic        load_unsigned,
  input  logic [31:0] word,
  output logic [31:0] result
);
  import mem_wb_stage_pkg::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane selection followed by extension according to the access size.
  always_comb begin
    byte_val = 8'h00;
    half_val = 16'h0000;
    result   = word;
    case (addr_lo)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    half_val = addr_lo[1] ? word[31:16] : word[15:0];
    case (load_type)
      BYTE:    result = load_unsigned ? {24'h000000, byte_val}
                                      : {{24{byte_val[7]}}, byte_val};
      HALF:    result = load_unsigned ? {16'h0000, half_val}
                                      : {{16{half_val[15]}}, half_val};
      default: result = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage                                                         |
// | Memory-access stage and MEM/WB register: issues load/store requests  |
// | on a valid/ready port, formats load data, selects and registers the  |
// | writeback value, and stalls upstream while a transaction is open.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rdata2_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic [4:0]  rd_i,
  input  logic        rf_en_i,
  input  logic        mem_write_i,
  input  logic        is_load_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  load_type_i,
  input  logic        load_unsigned_i,
  input  logic [2:0]  store_type_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_wstrb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rsp_valid_i,
  input  logic [31:0] dmem_rsp_data_i,
  output logic        stall_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  import mem_wb_stage_pkg::*;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        mem_op, misaligned, aligned_op;
  logic [2:0]  acc_size;
  logic        req_valid, store_accept, rsp_hit, timeout_hit, commit, done;
  logic        wb_en_nxt;
  logic [31:0] load_val, wb_val;

  mem_wb_stage_load_align u_load_align (
    .addr_lo       (alu_result_i[1:0]),
    .load_type     (load_type_i),
    .load_unsigned (load_unsigned_i),
    .word          (dmem_rsp_data_i),
    .result        (load_val)
  );

  // Decode the access and pick the writeback source from the EX/MEM inputs.
  always_comb begin
    mem_op     = is_load_i | mem_write_i;
    acc_size   = is_load_i ? load_type_i : store_type_i;
    misaligned = mem_op & access_misaligned(acc_size, alu_result_i[1:0]);
    aligned_op = mem_op & ~misaligned;
    if (is_jal_i | is_jalr_i) begin
      wb_val = pc_plus_4_i;
    end else if (is_load_i) begin
      wb_val = load_val;
    end else begin
      wb_val = alu_result_i;
    end
  end

  // Handshake FSM: request in IDLE, wait for the load response or timeout.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    req_valid    = 1'b0;
    store_accept = 1'b0;
    rsp_hit      = 1'b0;
    timeout_hit  = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_op) begin
          req_valid = 1'b1;
          if (dmem_req_ready_i) begin
            if (is_load_i) begin
              state_nxt = WAIT_RSP;
              cnt_nxt   = '0;
            end else begin
              store_accept = 1'b1;
              commit       = 1'b1;
            end
          end
        end else begin
          // Non-memory, bubble or dropped misaligned access retires at once.
          commit = 1'b1;
        end
      end
      WAIT_RSP: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A response in the timeout cycle still counts as a good load.
        if (dmem_rsp_valid_i) begin
          rsp_hit   = 1'b1;
          commit    = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == TMO_VAL)) begin
          timeout_hit = 1'b1;
          commit      = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-facing outputs; valid and stall are forced low while reset is held.
  always_comb begin
    done             = store_accept | rsp_hit | timeout_hit;
    dmem_req_valid_o = rst & req_valid;
    stall_o          = rst & aligned_op & ~done;
    dmem_addr_o      = {alu_result_i[31:2], 2'b00};
    dmem_we_o        = mem_write_i & ~is_load_i;
    dmem_wstrb_o     = dmem_we_o ? store_strobe(store_type_i, alu_result_i[1:0]) : 4'b0000;
    dmem_wdata_o     = store_lanes(store_type_i, rdata2_i);
    wb_en_nxt        = commit & rf_en_i & (rd_i != 5'd0) & ~misaligned & ~timeout_hit;
  end

  // State, timeout counter and the MEM/WB register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_en_o    <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= 32'd0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wb_en_o    <= wb_en_nxt;
      misalign_o <= (state == IDLE) & misaligned;
      bus_err_o  <= timeout_hit;
      if (commit) begin
        wb_rd_o   <= rd_i;
        wb_data_o <= wb_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_wb_stage                                                      |
// | Self-checking bench for mem_wb_stage: directed vector table, a reset |
// | abort sequence and randomized instructions against a reference model.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_wb_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, rdata2, pc_plus_4;
  logic [4:0]  rd;
  logic        rf_en, mem_write, is_load, is_jal, is_jalr;
  logic [2:0]  load_type, store_type;
  logic        load_unsigned;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        stall, wb_en, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.TIMEOUT(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_result_i     (alu_result),
    .rdata2_i         (rdata2),
    .pc_plus_4_i      (pc_plus_4),
    .rd_i             (rd),
    .rf_en_i          (rf_en),
    .mem_write_i      (mem_write),
    .is_load_i        (is_load),
    .is_jal_i         (is_jal),
    .is_jalr_i        (is_jalr),
    .load_type_i      (load_type),
    .load_unsigned_i  (load_unsigned),
    .store_type_i     (store_type),
    .dmem_req_valid_o (dmem_req_valid),
    .dmem_req_ready_i (dmem_req_ready),
    .dmem_addr_o      (dmem_addr),
    .dmem_we_o        (dmem_we),
    .dmem_wstrb_o     (dmem_wstrb),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_rsp_valid_i (dmem_rsp_valid),
    .dmem_rsp_data_i  (dmem_rsp_data),
    .stall_o          (stall),
    .wb_en_o          (wb_en),
    .wb_rd_o          (wb_rd),
    .wb_data_o        (wb_data),
    .misalign_o       (misalign),
    .bus_err_o        (bus_err)
  );

  always #5 clk = ~clk;

  // One instruction plus the memory behaviour it sees, and what must come out.
  typedef struct {
    logic [31:0] alu, rd2, pc4;
    logic [4:0]  rd;
    logic        rf_en, mw, ld, jal, jalr, lu;
    logic [2:0]  lt, st;
    int          rdy_dly;   // request cycles with ready low before accept
    int          rsp_wait;  // wait cycles before response; > T means none
    logic [31:0] rsp_data;
    logic        e_wb_en;
    logic [31:0] e_wb_data;
    logic        e_mis, e_berr;
    int          e_stall, e_req;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: expected results from the access rules, in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int off, sz;
    bit memop, misal, tmo;
    logic [31:0] val;
    r     = v;
    off   = int'(v.alu[1:0]);
    sz    = v.ld ? int'(v.lt) : int'(v.st);
    memop = v.ld || v.mw;
    misal = memop && !((sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0));
    tmo   = v.ld && !misal && (v.rsp_wait > T);
    if (v.lt == 3'd0) begin
      val = (v.rsp_data >> (8 * off)) & 32'hFF;
      if (!v.lu && val >= 32'h80) val = val - 32'h100;
    end else if (v.lt == 3'd1) begin
      val = (v.rsp_data >> (16 * (off / 2))) & 32'hFFFF;
      if (!v.lu && val >= 32'h8000) val = val - 32'h10000;
    end else begin
      val = v.rsp_data;
    end
    r.e_mis     = misal;
    r.e_berr    = tmo;
    r.e_req     = (memop && !misal) ? v.rdy_dly + 1 : 0;
    if (!memop || misal)  r.e_stall = 0;
    else if (!v.ld)       r.e_stall = v.rdy_dly;
    else                  r.e_stall = v.rdy_dly + 1 + (tmo ? T : v.rsp_wait);
    r.e_wb_data = (v.jal || v.jalr) ? v.pc4 : (v.ld ? val : v.alu);
    r.e_wb_en   = v.rf_en && (v.rd != 5'd0) && !misal && !tmo;
    if (v.st == 3'd0)      r.e_wstrb = 4'(1 << off);
    else if (v.st == 3'd1) r.e_wstrb = (off >= 2) ? 4'hC : 4'h3;
    else                   r.e_wstrb = 4'hF;
    if (v.st == 3'd0)      r.e_wdata = {24'd0, v.rd2[7:0]} * 32'h01010101;
    else if (v.st == 3'd1) r.e_wdata = {16'd0, v.rd2[15:0]} * 32'h00010001;
    else                   r.e_wdata = v.rd2;
    return r;
  endfunction

  task automatic drive_instr(input vec_t v);
    alu_result = v.alu; rdata2 = v.rd2; pc_plus_4 = v.pc4; rd = v.rd;
    rf_en = v.rf_en; mem_write = v.mw; is_load = v.ld; is_jal = v.jal; is_jalr = v.jalr;
    load_type = v.lt; load_unsigned = v.lu; store_type = v.st;
  endtask

  // Hold one instruction at the inputs until stall drops, acting as memory.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, stalls, reqs, waitc;
    bit accepted, fin;
    cyc = 0; stalls = 0; reqs = 0; waitc = 0; accepted = 0; fin = 0;
    drive_instr(v);
    while (!fin) begin
      dmem_req_ready = !accepted && (cyc >= v.rdy_dly);
      if (accepted) begin
        dmem_rsp_valid = (waitc == v.rsp_wait);
        dmem_rsp_data  = dmem_rsp_valid ? v.rsp_data : $urandom;
      end else begin
        dmem_rsp_valid = 1'($urandom_range(0, 1));  // stray response while idle
        dmem_rsp_data  = $urandom;
      end
      #1;
      if (dmem_req_valid) begin
        reqs++;
        chk($sformatf("v%0d addr", idx), dmem_addr, {v.alu[31:2], 2'b00});
        chk($sformatf("v%0d we", idx), 32'(dmem_we), 32'(v.mw && !v.ld));
        if (v.mw && !v.ld) begin
          chk($sformatf("v%0d wstrb", idx), 32'(dmem_wstrb), 32'(v.e_wstrb));
          chk($sformatf("v%0d wdata", idx), dmem_wdata, v.e_wdata);
        end
      end
      if (stall) stalls++;
      else fin = 1;
      if (accepted) waitc++;
      else if (dmem_req_valid && dmem_req_ready) accepted = 1;
      @(posedge clk); #1;
      if (!fin) chk($sformatf("v%0d bubble", idx), 32'(wb_en), 32'd0);
      cyc++;
      if (!fin && cyc >= 40) begin
        total++; bad++;
        $display("FAIL v%0d budget: stall still %b after %0d cycles, want low", idx, stall, cyc);
        fin = 1;
      end
    end
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    chk($sformatf("v%0d stalls", idx), 32'(stalls), 32'(v.e_stall));
    chk($sformatf("v%0d reqs", idx), 32'(reqs), 32'(v.e_req));
    chk($sformatf("v%0d wb_en", idx), 32'(wb_en), 32'(v.e_wb_en));
    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(v.e_mis));
    chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.e_berr));
    if (v.e_wb_en) begin
      chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
      chk($sformatf("v%0d wb_data", idx), wb_data, v.e_wb_data);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int k;

    // Reset with an aligned load at the inputs: no request, no stall, outputs 0.
    rst = 1'b0;
    v = '{default: 0};
    v.alu = 32'h100; v.ld = 1; v.lt = 3'd2; v.rf_en = 1; v.rd = 5'd4;
    drive_instr(v);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h1;
    #12;
    chk("rst req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    v = '{default: 0};
    drive_instr(v);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-derived expectations (TIMEOUT = 4).
    v = '{default: 0}; v.alu = 32'h5; v.rd = 5'd3; v.rf_en = 1;
    v.e_wb_en = 1; v.e_wb_data = 32'h5; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h103; v.rd = 5'd5; v.rf_en = 1; v.ld = 1; v.lt = 3'd0;
    v.rsp_wait = 2; v.rsp_data = 32'h80AABBCC;
    v.e_wb_en = 1; v.e_wb_data = 32'hFFFFFF80; v.e_stall = 3; v.e_req = 1; tbl.push_back(v);
    v.lu = 1; v.e_wb_data = 32'h00000080; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h202; v.rd2 = 32'h1234ABCD; v.mw = 1; v.st = 3'd1; v.rdy_dly = 1;
    v.e_stall = 1; v.e_req = 2; v.e_wstrb = 4'b1100; v.e_wdata = 32'hABCDABCD; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h101; v.rd = 5'd7; v.rf_en = 1; v.ld = 1; v.lt = 3'd2;
    v.rsp_wait = 0; v.e_mis = 1; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h300; v.rd = 5'd8; v.rf_en = 1; v.ld = 1; v.lt = 3'd2;
    v.rsp_wait = 99; v.e_berr = 1; v.e_stall = 5; v.e_req = 1; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h77; v.rd = 5'd9; v.rf_en = 1;
    v.e_wb_en = 1; v.e_wb_data = 32'h77; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h1234; v.pc4 = 32'h44; v.rd = 5'd1; v.rf_en = 1; v.jal = 1;
    v.e_wb_en = 1; v.e_wb_data = 32'h44; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h10; v.rd = 5'd0; v.rf_en = 1; v.ld = 1; v.lt = 3'd2;
    v.rsp_data = 32'hDEADBEEF; v.e_stall = 1; v.e_req = 1; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h206; v.rd = 5'd11; v.rf_en = 1; v.ld = 1; v.lt = 3'd1;
    v.rsp_wait = 1; v.rsp_data = 32'h80017FFF;
    v.e_wb_en = 1; v.e_wb_data = 32'hFFFF8001; v.e_stall = 2; v.e_req = 1; tbl.push_back(v);
    v.lu = 1; v.e_wb_data = 32'h00008001; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h3; v.rd2 = 32'h0000005A; v.mw = 1; v.st = 3'd0;
    v.e_req = 1; v.e_wstrb = 4'b1000; v.e_wdata = 32'h5A5A5A5A; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h8; v.rd2 = 32'hCAFEF00D; v.mw = 1; v.st = 3'd2;
    v.e_req = 1; v.e_wstrb = 4'b1111; v.e_wdata = 32'hCAFEF00D; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h40; v.rd = 5'd10; v.rf_en = 1; v.ld = 1; v.lt = 3'd2;
    v.rsp_wait = 4; v.rsp_data = 32'h11223344;
    v.e_wb_en = 1; v.e_wb_data = 32'h11223344; v.e_stall = 5; v.e_req = 1; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h0; v.mw = 1; v.st = 3'd3; v.e_mis = 1; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h9; v.pc4 = 32'h100; v.rd = 5'd2; v.rf_en = 1; v.jalr = 1;
    v.e_wb_en = 1; v.e_wb_data = 32'h100; tbl.push_back(v);
    v = '{default: 0}; tbl.push_back(v);
    v = '{default: 0}; v.alu = 32'h101; v.rd = 5'd12; v.rf_en = 1; v.ld = 1; v.lt = 3'd0;
    v.rsp_data = 32'h80AABBCC; v.e_wb_en = 1; v.e_wb_data = 32'hFFFFFFBB;
    v.e_stall = 1; v.e_req = 1; tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Reset while waiting for a load response aborts it; the late response is ignored.
    v = '{default: 0}; v.alu = 32'h100; v.ld = 1; v.lt = 3'd2; v.rf_en = 1; v.rd = 5'd4;
    drive_instr(v);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    #1;
    chk("abort req", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #1;
    chk("abort wait stall", 32'(stall), 32'd1);
    chk("abort wait req", 32'(dmem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort rst stall", 32'(stall), 32'd0);
    chk("abort rst wb_data", wb_data, 32'd0);
    chk("abort rst wb_en", 32'(wb_en), 32'd0);
    v = '{default: 0};
    drive_instr(v);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h55;
    #1;
    chk("late rsp stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    chk("late rsp wb_en", 32'(wb_en), 32'd0);
    chk("late rsp bus_err", 32'(bus_err), 32'd0);
    v = '{default: 0}; v.alu = 32'hABC; v.rd = 5'd6; v.rf_en = 1;
    v = model(v);
    run_vec(v, 99);

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 200; i++) begin
      v = '{default: 0};
      v.alu = $urandom; v.rd2 = $urandom; v.pc4 = $urandom; v.rsp_data = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.rf_en = 1'($urandom_range(0, 1));
      v.lu = 1'($urandom_range(0, 1));
      v.lt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v.st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v.rdy_dly = $urandom_range(0, 2);
      v.rsp_wait = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, T);
      k = $urandom_range(0, 9);
      case (k)
        2: v.jal = 1;
        3: v.jalr = 1;
        4, 5, 6: v.ld = 1;
        7, 8: v.mw = 1;
        9: v.rf_en = 0;
        default: ;
      endcase
      if ((v.ld || v.mw) && $urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
      v = model(v);
      run_vec(v, 100 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
